// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS load/store path: access size encodings,
// load/store FSM states and the default memory timeout.
package mips_pkg;

  typedef enum logic [1:0] {
    LsByte    = 2'b00,
    LsHalf    = 2'b01,
    LsWord    = 2'b10,
    LsIllegal = 2'b11
  } ls_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } ls_state_e;

  localparam int unsigned TimeoutDefault = 16;

endpackage

// File: rtl/ls_align.sv
// Lane alignment for the load/store unit: byte enables and lane-replicated
// store data for the outgoing request, and right-aligned, extended load data
// taken from the returned word.
module ls_align
  import mips_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Decode enables, replicate store lanes and pick/extend the load lanes.
  always_comb begin
    byte_en   = 4'b1111;
    lane_data = store_data;
    load_data = read_word;
    byte_sel  = read_word[7:0];
    half_sel  = read_word[15:0];
    case (ls_size_e'(size))
      LsByte: begin
        byte_en   = 4'b0001 << offset;
        lane_data = {4{store_data[7:0]}};
        case (offset)
          2'd0:    byte_sel = read_word[7:0];
          2'd1:    byte_sel = read_word[15:8];
          2'd2:    byte_sel = read_word[23:16];
          default: byte_sel = read_word[31:24];
        endcase
        load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      end
      LsHalf: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
        half_sel  = offset[1] ? read_word[31:16] : read_word[15:0];
        load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        byte_en   = 4'b1111;
        lane_data = store_data;
        load_data = read_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates a CONTROL access, issues a single memory request,
// waits for mem_ack (bounded by TIMEOUT) and formats load results.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  LsSize,
  input  logic        LsSigned,
  input  logic [31:0] ALUOut,
  input  logic [31:0] ReadData2,
  output logic [31:0] ReadData3,
  output logic        Stall,
  output logic        AccErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  ls_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]  off_q, size_q;
  logic        signed_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [3:0]  be_q;
  logic        err_q, err_d;
  logic        accept, aligned, valid, in_idle;

  logic [1:0]  al_off, al_size;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  // Alignment rules for the live request.
  always_comb begin
    aligned = 1'b0;
    case (ls_size_e'(LsSize))
      LsByte:  aligned = 1'b1;
      LsHalf:  aligned = ~ALUOut[0];
      LsWord:  aligned = (ALUOut[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign valid   = (MemRead ^ MemWrite) & aligned;
  assign in_idle = (state_q == StIdle);

  // One aligner serves both directions: live inputs while deciding whether to
  // accept, captured attributes while the load data comes back.
  assign al_off    = in_idle ? ALUOut[1:0] : off_q;
  assign al_size   = in_idle ? LsSize      : size_q;
  assign al_signed = in_idle ? LsSigned    : signed_q;

  ls_align u_ls_align (
    .offset     (al_off),
    .size       (al_size),
    .is_signed  (al_signed),
    .store_data (ReadData2),
    .read_word  (mem_rdata),
    .byte_en    (al_be),
    .lane_data  (al_wdata),
    .load_data  (al_load)
  );

  // Next-state, timeout counter, error pulse, load capture and Stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    accept  = 1'b0;
    Stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (valid) begin
          accept  = 1'b1;
          Stall   = 1'b1;
          state_d = StReq;
          cnt_d   = '0;
        end else if (MemRead | MemWrite) begin
          err_d = 1'b1;
        end
      end
      StReq: begin
        Stall = 1'b1;
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) rdata_d = al_load;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and captured request registers; request fields latch only on accept.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      off_q    <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        off_q    <= ALUOut[1:0];
        size_q   <= LsSize;
        signed_q <= LsSigned;
        we_q     <= MemWrite;
        addr_q   <= {ALUOut[31:2], 2'b00};
        be_q     <= al_be;
        wdata_q  <= al_wdata;
      end
    end
  end

  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ReadData3 = rdata_q;
  assign AccErr    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected requests and load results
// are queued when an access is driven and popped when the DUT responds.
module tb_load_store_unit;

  localparam int unsigned To = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemRead, MemWrite, LsSigned, mem_ack;
  logic [1:0]  LsSize;
  logic [31:0] ALUOut, ReadData2, mem_rdata;
  logic [31:0] ReadData3, mem_addr, mem_wdata;
  logic        Stall, AccErr, mem_req, mem_we;
  logic [3:0]  mem_be;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rd3;
  int          checks = 0;
  int          failures = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.TIMEOUT(To)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .LsSize    (LsSize),
    .LsSigned  (LsSigned),
    .ALUOut    (ALUOut),
    .ReadData2 (ReadData2),
    .ReadData3 (ReadData3),
    .Stall     (Stall),
    .AccErr    (AccErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic model_valid(input logic rd, input logic wr, input logic [1:0] sz,
                                       input logic [31:0] a);
    if (rd == wr) return 1'b0;
    if (sz == 2'b11) return 1'b0;
    if (sz == 2'b01 && a[0]) return 1'b0;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'b0001 << off;
    if (sz == 2'b01) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                             input logic [1:0] off, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * off);
    if (sz == 2'b00) return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    if (sz == 2'b01) return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    return w;
  endfunction

  // Drive one access; ack_dly = REQ cycle in which mem_ack is raised, 0 = never.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_dly);
    logic vld;
    req_t exp_req;
    logic [31:0] exp_load;
    int   cyc;
    int   stall_cnt;
    @(negedge CLK);
    MemRead = rd; MemWrite = wr; LsSize = sz; LsSigned = sgn; ALUOut = a; ReadData2 = wd;
    #1;
    vld = model_valid(rd, wr, sz, a);
    chk({tag, "_stall_idle"}, {31'h0, Stall}, {31'h0, vld});
    if (!vld) begin
      @(negedge CLK);
      chk({tag, "_err_pulse"}, {31'h0, AccErr}, 32'h1);
      chk({tag, "_no_req"}, {31'h0, mem_req}, 32'h0);
      chk({tag, "_stall_low"}, {31'h0, Stall}, 32'h0);
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge CLK);
      chk({tag, "_err_one_cycle"}, {31'h0, AccErr}, 32'h0);
      chk({tag, "_no_req2"}, {31'h0, mem_req}, 32'h0);
      return;
    end
    req_q.push_back('{addr: {a[31:2], 2'b00}, be: model_be(sz, a[1:0]), we: wr,
                      wdata: model_wdata(sz, wd)});
    if (rd && ack_dly != 0) rd_q.push_back(model_load(sz, sgn, a[1:0], rdata));
    stall_cnt = 1;
    @(negedge CLK);
    // Scramble inputs to confirm the request was captured at acceptance.
    MemRead = 1'b0; MemWrite = 1'b0; LsSize = 2'b11; LsSigned = ~sgn;
    ALUOut = 32'hDEAD_BEEF; ReadData2 = ~wd;
    exp_req = '0;
    cyc = 0;
    while (mem_req && cyc < To + 8) begin
      if (cyc == 0) exp_req = req_q.pop_front();
      chk({tag, "_addr"}, mem_addr, exp_req.addr);
      chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_req.be});
      chk({tag, "_we"}, {31'h0, mem_we}, {31'h0, exp_req.we});
      chk({tag, "_wdata"}, mem_wdata, exp_req.wdata);
      stall_cnt += int'(Stall);
      cyc++;
      if (ack_dly != 0 && cyc == ack_dly) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      @(negedge CLK);
      mem_ack = 1'b0; mem_rdata = 32'hA5A5_5A5A;
    end
    if (ack_dly != 0) begin
      chk({tag, "_req_cycles"}, cyc, ack_dly);
      chk({tag, "_stall_cycles"}, stall_cnt, 1 + ack_dly);
      chk({tag, "_stall_done"}, {31'h0, Stall}, 32'h0);
      chk({tag, "_no_err"}, {31'h0, AccErr}, 32'h0);
      if (rd) exp_rd3 = rd_q.pop_front();
      chk({tag, "_rdata3"}, ReadData3, exp_rd3);
    end else begin
      chk({tag, "_timeout_cycles"}, cyc, To);
      chk({tag, "_timeout_err"}, {31'h0, AccErr}, 32'h1);
      chk({tag, "_timeout_rd3"}, ReadData3, exp_rd3);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge CLK);
      mem_ack = 1'b0;
      chk({tag, "_late_ack_rd3"}, ReadData3, exp_rd3);
      chk({tag, "_late_ack_req"}, {31'h0, mem_req}, 32'h0);
      chk({tag, "_err_one_cycle"}, {31'h0, AccErr}, 32'h0);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    RESET = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; LsSize = 2'b10; LsSigned = 1'b0;
    ALUOut = '0; ReadData2 = '0; mem_rdata = '0; mem_ack = 1'b0;
    exp_rd3 = '0;
    repeat (2) @(negedge CLK);
    chk("rst_rd3", ReadData3, 32'h0);
    chk("rst_err", {31'h0, AccErr}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    RESET = 1'b1;

    run_access("lw",    1, 0, 2'b10, 0, 32'h10, 32'h0,        32'h1122_3344, 3);
    run_access("lb",    1, 0, 2'b00, 1, 32'h13, 32'h0,        32'h80FF_0000, 1);
    run_access("lbu",   1, 0, 2'b00, 0, 32'h13, 32'h0,        32'h80FF_0000, 2);
    run_access("sh",    0, 1, 2'b01, 0, 32'h22, 32'h0000_BEEF, 32'h0,        2);
    run_access("sb",    0, 1, 2'b00, 0, 32'h01, 32'h1234_5678, 32'h0,        1);
    run_access("sw",    0, 1, 2'b10, 0, 32'h44, 32'hCAFE_F00D, 32'h0,        4);
    run_access("lh",    1, 0, 2'b01, 1, 32'h02, 32'h0,        32'h8001_7FFF, 1);
    run_access("lhu",   1, 0, 2'b01, 0, 32'h00, 32'h0,        32'h8001_F00F, 1);
    run_access("mis_w", 1, 0, 2'b10, 0, 32'h06, 32'h0,        32'h0,        1);
    run_access("rd_wr", 1, 1, 2'b10, 0, 32'h10, 32'h0,        32'h0,        1);
    run_access("ill_sz",1, 0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1);
    run_access("mis_h", 0, 1, 2'b01, 0, 32'h21, 32'h0,        32'h0,        1);
    run_access("tmo",   1, 0, 2'b10, 0, 32'h30, 32'h0,        32'h0,        0);

    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & 32'hFFFF_FFF0;
      if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'b01) a[1] = 1'($urandom_range(0, 1));
      run_access("rnd", 1, 0, sz, 1'($urandom_range(0, 1)), a, 32'h0, $urandom,
                 $urandom_range(1, 4));
    end

    // Reset in the middle of a request.
    @(negedge CLK);
    MemRead = 1'b1; LsSize = 2'b10; ALUOut = 32'h40;
    @(negedge CLK);
    MemRead = 1'b0;
    chk("rstreq_req_before", {31'h0, mem_req}, 32'h1);
    RESET = 1'b0;
    @(negedge CLK);
    exp_rd3 = 32'h0;
    chk("rstreq_req", {31'h0, mem_req}, 32'h0);
    chk("rstreq_rd3", ReadData3, exp_rd3);
    chk("rstreq_err", {31'h0, AccErr}, 32'h0);
    chk("rstreq_stall", {31'h0, Stall}, 32'h0);
    RESET = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge CLK);
    mem_ack = 1'b0;
    chk("rstreq_late_rd3", ReadData3, exp_rd3);
    chk("rstreq_late_err", {31'h0, AccErr}, 32'h0);
    chk("rstreq_late_req", {31'h0, mem_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
